apb_mem_slave: RTL
==================

# apb_mem_slave

Parametrised APB4 memory-mapped slave with byte-lane strobes, configurable wait states, a read-only low region and deterministic error responses. It is the next-generation memory target on the APB fabric. It sits behind the APB decoder/bridge as a scratchpad or register-image store. Transfers are always `2 + WAIT_STATES` cycles, with no idle cycle needed between back-to-back transfers.

## Interface
Parameters:
- `DATA_WIDTH`, 32: data bus width; legal values 8, 16, 32, 64.
- `ADDR_WIDTH`, 32: width of `paddr`.
- `DEPTH`, 64: number of `DATA_WIDTH` words; ≥ 2.
- `WAIT_STATES`, 0: extra access cycles before `pready`; 0..15.
- `WP_WORDS`, 0: word indices `[0, WP_WORDS)` are write-protected; 0 ≤ `WP_WORDS` ≤ `DEPTH`.

Ports:
- `pclk`  in  1  clock. All logic is clocked on the rising edge.
- `presetn`  in  1  reset; asynchronous, active-low.
- `psel`  in  1  slave select.
- `penable`  in  1  access phase.
- `pwrite`  in  1  1 = write, 0 = read.
- `paddr`  in  `ADDR_WIDTH`  byte address.
- `pwdata`  in  `DATA_WIDTH`  write data.
- `pstrb`  in  `DATA_WIDTH/8`  write byte-lane enables; ignored on reads.
- `prdata`  out  `DATA_WIDTH`  read data; valid only while `pready`=1 on a read.
- `pready`  out  1  transfer completes.
- `pslverr`  out  1  error response; qualified by `pready`.

## Operation
- `LSB` = log2(`DATA_WIDTH/8`).
- Word index = `paddr[ADDR_WIDTH-1:LSB]`, compared full-width against `DEPTH`. No wrap or truncation.
- Error conditions, evaluated at the setup edge:
  - misaligned: `paddr[LSB-1:0]` ≠ 0, when `LSB` > 0;
  - out of range: index ≥ `DEPTH`;
  - write-protected: write with index < `WP_WORDS`.
- Errored write: memory unchanged.
- Errored read: `prdata` = 0.
- Write: each byte lane `i` with `pstrb[i]`=1 is updated; the other lanes keep their value. `pstrb`=0 gives an OKAY response and no change.
- Read: at the setup edge, `prdata` is registered from the memory word.
- Memory contents are cleared to 0 on reset.
- FSM states:
  - IDLE → ACCESS on `psel & !penable`. Load wait counter with `WAIT_STATES`. Register `prdata`, the error flag and the address/write control.
  - IDLE with `penable`=1 but no preceding setup: ignored, stay in IDLE.
  - ACCESS, counter > 0: decrement the counter and hold.
  - ACCESS, counter = 0, `psel & penable`: transfer completes at this edge. The write is committed here, if any and not errored. Next state is IDLE.
  - ACCESS with `psel`=0 (abort): → IDLE, no memory update.
  - Invalid encoding: → IDLE.
- `pready` = (state == ACCESS) && (counter == 0). It is a Moore output, decoded from registers only.
- `pslverr` = `pready` && error flag. Both are 0 in every other cycle.

## Timing
- Reset values:
  - state IDLE, counter 0;
  - `prdata` = 0, `pready` = 0, `pslverr` = 0;
  - all memory words = 0.
- Asserting reset mid-transfer forces these values immediately. The in-flight write is dropped.
- Latency:
  - setup cycle, then `pready` rises in access cycle number `WAIT_STATES+1`;
  - the transfer occupies `WAIT_STATES+2` cycles.
- Back-to-back transfers: the completion edge returns to IDLE. The next setup phase is sampled on the following edge, so there are no dead cycles.
- Read data reflects every write completed before the read's setup edge.
- `prdata` holds its last value outside read completion. The bench checks it only when `pready & !pwrite`.

## Structure
- Package `apb_mem_pkg`: the state enum (`IDLE`, `ACCESS`), the response-type constants (`OKAY`, `SLVERR`), and a localparam helper for `LSB`/strobe width.
- Sub-module `apb_mem_array` contains the `DEPTH` × `DATA_WIDTH` storage:
  - byte-enable synchronous write;
  - registered read port;
  - async clear.
- `apb_mem_slave` holds the FSM, wait counter, address decode and error logic.

## Test plan
- Reset during an ACCESS wait state (`WAIT_STATES`=2) → `pready`, `pslverr` and `prdata` are 0 without a clock edge. A later read of 0x14 returns 0x00000000 with OKAY.
- Write 0xDEADBEEF to 0x10 with `pstrb`=4'b1111, then 0x000000AA with `pstrb`=4'b0001, then read 0x10 (`WAIT_STATES`=0):
  - `pready` is high in the first access cycle;
  - the read returns 0xDEADBEAA with `pslverr`=0.
- `WAIT_STATES`=3, read 0x04 → `pready` is low for 3 access cycles and high on the 4th; total 5 cycles. A back-to-back write with its setup on the next cycle completes with no gap.
- Error responses (`DEPTH`=64):
  - write to 0x100 → `pslverr`=1 with `pready`, and word 63 is unchanged;
  - read of 0x12 → `pslverr`=1, `prdata`=0.
- Write protection (`WP_WORDS`=4): write 0x12345678 to 0x08 → `pslverr`=1, and a later read of 0x08 returns the old value with OKAY. A write to 0x10 succeeds.
- Abort (`WAIT_STATES`=2): drop `psel` in the 2nd access cycle of a write to 0x20 → no `pready`, memory unchanged, FSM back in IDLE. The next read of 0x20 completes normally.

Source files
------------

// File: rtl/apb_mem_pkg.sv
// Shared types and helpers for the APB memory slave and its storage array.
package apb_mem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01
  } state_e;

  localparam logic OKAY   = 1'b0;
  localparam logic SLVERR = 1'b1;

  function automatic int lsb_of(input int data_width);
    return $clog2(data_width / 8);
  endfunction

  function automatic int strb_w(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/apb_mem_array.sv
// DEPTH x DATA_WIDTH storage: byte-enable synchronous write, registered read, async clear.
module apb_mem_array
  import apb_mem_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  DEPTH      = 64,
  localparam int SW         = strb_w(DATA_WIDTH),
  localparam int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [SW-1:0]         wstrb,
  input  logic                  re,
  input  logic                  rclr,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;

  always_comb begin
    mem_d = mem_q;
    if (we) begin
      for (int i = 0; i < SW; i++) begin
        if (wstrb[i]) mem_d[waddr][8*i +: 8] = wdata[8*i +: 8];
      end
    end
  end

  // A rejected read loads zero so an errored response never leaks stale data.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = rclr ? '0 : mem_q[raddr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < DEPTH; w++) mem_q[w] <= '0;
      rdata_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/apb_mem_slave.sv
// APB4 memory slave: setup/access FSM, wait-state counter, address decode and error responses.
module apb_mem_slave
  import apb_mem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 0,
  parameter int WP_WORDS    = 0
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int LSB   = lsb_of(DATA_WIDTH);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((64'd1 << LSB) - 64'd1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A    = ADDR_WIDTH'(DEPTH);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             write_q, write_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic [ADDR_WIDTH-1:0] word_idx;
  logic                  misaligned;
  logic                  out_of_range;
  logic                  protected_wr;
  logic                  req_err;
  logic                  mem_we;
  logic                  mem_re;

  // Full-width index compare: high address bits never alias into the array.
  assign word_idx     = paddr >> LSB;
  assign misaligned   = (paddr & ALIGN_MASK) != '0;
  assign out_of_range = word_idx >= DEPTH_A;

  generate
    if (WP_WORDS > 0) begin : g_wp
      assign protected_wr = pwrite && (word_idx < ADDR_WIDTH'(WP_WORDS));
    end else begin : g_no_wp
      assign protected_wr = 1'b0;
    end
  endgenerate

  assign req_err = misaligned | out_of_range | protected_wr;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    write_d = write_q;
    idx_d   = idx_q;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d = ACCESS;
          cnt_d   = 4'(WAIT_STATES);
          err_d   = req_err ? SLVERR : OKAY;
          write_d = pwrite;
          idx_d   = word_idx[IDX_W-1:0];
          mem_re  = !pwrite;
        end
      end
      ACCESS: begin
        // Deselect wins over the counter so an abort never commits the write.
        if (!psel) begin
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else if (penable) begin
          state_d = IDLE;
          mem_we  = write_q && (err_q == OKAY);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      err_q   <= OKAY;
      write_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      write_q <= write_d;
      idx_q   <= idx_d;
    end
  end

  assign pready  = (state_q == ACCESS) && (cnt_q == 4'd0);
  assign pslverr = pready && (err_q == SLVERR);

  apb_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_array (
    .clk   (pclk),
    .rst_n (presetn),
    .we    (mem_we),
    .waddr (idx_q),
    .wdata (pwdata),
    .wstrb (pstrb),
    .re    (mem_re),
    .rclr  (req_err),
    .raddr (word_idx[IDX_W-1:0]),
    .rdata (prdata)
  );

endmodule
